// File: rtl/sr_bus_arbiter.sv
// Arbiter for the shared 8-bit uio bus: TX/RX requesters alternate fairly,
// bursts are capped, and every direction change inserts idle turnaround cycles.
module sr_bus_arbiter #(
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ack,
  input  logic       rx_req,
  input  logic [7:0] bus_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  output logic       busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {IDLE, TURN, TX, RX} state_e;

  // dir: 1 = bus driven (OUT), 0 = bus sampled (IN); last_grant: 1 = TX, 0 = RX
  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic          last_grant_q, last_grant_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [7:0]    bus_out_q, bus_out_d;
  logic [7:0]    bus_oe_q, bus_oe_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          winner;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    last_grant_d = last_grant_q;
    turn_d       = turn_q;
    burst_d      = burst_q;
    bus_out_d    = bus_out_q;
    bus_oe_d     = bus_oe_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    tx_ack       = 1'b0;
    winner       = last_grant_q;

    if (!ena) begin
      state_d  = IDLE;
      bus_oe_d = 8'h00;
      dir_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bus_oe_d = {8{dir_q}};
          if (tx_req || rx_req) begin
            // on a tie the side that did not hold the last grant wins
            winner       = (tx_req && rx_req) ? ~last_grant_q : tx_req;
            last_grant_d = winner;
            burst_d      = '0;
            if (winner == dir_q) begin
              state_d = winner ? TX : RX;
            end else begin
              state_d  = TURN;
              bus_oe_d = 8'h00;
              turn_d   = TW'(TURN_CYC - 1);
            end
          end
        end
        TURN: begin
          bus_oe_d = 8'h00;
          if (turn_q == '0) begin
            dir_d    = last_grant_q;
            burst_d  = '0;
            bus_oe_d = {8{last_grant_q}};
            state_d  = last_grant_q ? TX : RX;
          end else begin
            turn_d = turn_q - 1'b1;
          end
        end
        TX: begin
          bus_oe_d = 8'hFF;
          tx_ack   = tx_req & rst_n;
          if (tx_req) begin
            bus_out_d = tx_data;
            burst_d   = burst_q + 1'b1;
            if (tx_last || burst_q == CW'(MAX_BURST - 1)) state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end
        RX: begin
          bus_oe_d = 8'h00;
          if (rx_req) begin
            rx_data_d  = bus_in;
            rx_valid_d = 1'b1;
            burst_d    = burst_q + 1'b1;
            if (burst_q == CW'(MAX_BURST - 1)) state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      last_grant_q <= 1'b0;
      turn_q       <= '0;
      burst_q      <= '0;
      bus_out_q    <= 8'h00;
      bus_oe_q     <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      last_grant_q <= last_grant_d;
      turn_q       <= turn_d;
      burst_q      <= burst_d;
      bus_out_q    <= bus_out_d;
      bus_oe_q     <= bus_oe_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
    end
  end

  assign bus_out  = bus_out_q;
  assign bus_oe   = bus_oe_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sr_bus_arbiter.sv
// Bench for sr_bus_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_sr_bus_arbiter;

  localparam int TURN_CYC  = 2;
  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst_n, ena, tx_req, tx_last, rx_req;
  logic [7:0] tx_data, bus_in;
  logic       tx_ack, rx_valid, busy;
  logic [7:0] rx_data, bus_out, bus_oe;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_bus_arbiter #(.TURN_CYC(TURN_CYC), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .tx_req(tx_req), .tx_data(tx_data), .tx_last(tx_last), .tx_ack(tx_ack),
    .rx_req(rx_req), .bus_in(bus_in), .rx_valid(rx_valid), .rx_data(rx_data),
    .bus_out(bus_out), .bus_oe(bus_oe), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: mode 0 = no grant, 1 = turning around, 2 = grant held
  // side/dir/last: 1 = transmit side (bus driven), 0 = receive side
  int         m_mode, m_side, m_dir, m_last, m_turn_left, m_count;
  logic [7:0] m_oe, m_out, m_rxd;
  logic       m_rxv;

  function automatic logic model_ack();
    return rst_n && ena && m_mode == 2 && m_side == 1 && tx_req;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_dir = 0; m_last = 0; m_turn_left = 0; m_count = 0;
      m_oe = 8'h00; m_out = 8'h00; m_rxv = 1'b0; m_rxd = 8'h00;
    end else if (!ena) begin
      m_mode = 0; m_oe = 8'h00; m_dir = 0; m_rxv = 1'b0;
    end else begin
      m_rxv = 1'b0;
      if (m_mode == 0) begin
        m_oe = (m_dir == 1) ? 8'hFF : 8'h00;
        if (tx_req || rx_req) begin
          if (tx_req && rx_req) m_side = 1 - m_last;
          else                  m_side = tx_req ? 1 : 0;
          m_last = m_side;
          m_count = 0;
          if (m_side == m_dir) m_mode = 2;
          else begin
            m_mode = 1; m_turn_left = TURN_CYC; m_oe = 8'h00;
          end
        end
      end else if (m_mode == 1) begin
        m_turn_left--;
        if (m_turn_left == 0) begin
          m_dir = m_side; m_mode = 2; m_count = 0;
          m_oe = (m_side == 1) ? 8'hFF : 8'h00;
        end
      end else if (m_side == 1) begin
        if (tx_req) begin
          m_out = tx_data; m_count++;
          if (tx_last || m_count == MAX_BURST) m_mode = 0;
        end else m_mode = 0;
      end else begin
        if (rx_req) begin
          m_rxd = bus_in; m_rxv = 1'b1; m_count++;
          if (m_count == MAX_BURST) m_mode = 0;
        end else m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_val("tx_ack", tx_ack, model_ack());
    @(posedge clk);
    model_step();
    #1;
    check_val("bus_oe", bus_oe, m_oe);
    check_val("bus_out", bus_out, m_out);
    check_val("rx_valid", rx_valid, m_rxv);
    check_val("rx_data", rx_data, m_rxd);
    check_val("busy", busy, m_mode != 0);
  endtask

  initial begin
    int   acks, nrx, k;
    logic pred;
    rst_n = 1'b0; ena = 1'b1; tx_req = 1'b0; tx_last = 1'b0; rx_req = 1'b0;
    tx_data = 8'h00; bus_in = 8'h00;
    m_side = 0;
    tick(); tick();
    check_val("rst_oe", bus_oe, 8'h00);
    rst_n = 1'b1;

    // three-byte packet from reset: 1 arbitration + 2 turnaround + 3 bytes
    acks = 0; k = 0;
    while (acks < 3 && k < 20) begin
      tx_req = 1'b1; tx_data = 8'hA1 + 8'(acks); tx_last = (acks == 2);
      pred = model_ack();
      tick(); k++;
      if (pred) acks++;
    end
    check_val("t1_len", k, 6);
    tx_req = 1'b0; tx_last = 1'b0;
    tick();
    check_val("t1_bus_out", bus_out, 8'hA3);
    check_val("t1_oe_idle", bus_oe, 8'hFF);

    // receive ramp with the bus already inbound: no turnaround
    ena = 1'b0; tick(); ena = 1'b1;
    nrx = 0;
    for (int i = 0; i < 8; i++) begin
      rx_req = (i < 7); bus_in = (i == 0) ? 8'h00 : 8'(i - 1);
      tick();
      if (rx_valid) nrx++;
    end
    check_val("t3_rx_count", nrx, 6);
    check_val("t3_last_byte", rx_data, 8'h05);

    // both sides requesting continuously: capped alternating bursts
    tx_req = 1'b1; rx_req = 1'b1; tx_last = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tx_data = 8'($urandom); bus_in = 8'($urandom);
      tick();
    end
    tx_req = 1'b0; rx_req = 1'b0; tick(); tick();

    // enable dropped after the fourth byte of a burst
    ena = 1'b0; tick(); ena = 1'b1;
    acks = 0; k = 0;
    while (k < 20) begin
      tx_req = 1'b1; tx_data = 8'($urandom);
      if (acks == 4) ena = 1'b0;
      pred = model_ack();
      tick(); k++;
      if (pred) acks++;
      if (!ena) break;
    end
    check_val("t4_busy", busy, 1'b0);
    check_val("t4_oe", bus_oe, 8'h00);
    ena = 1'b1; tick();
    check_val("t4_turn_oe", bus_oe, 8'h00);
    check_val("t4_turn_busy", busy, 1'b1);
    tx_req = 1'b0; for (int i = 0; i < 4; i++) tick();

    // reset pulse during receive, then a tie must go to transmit
    rx_req = 1'b1; k = 0;
    while (!(m_mode == 2 && m_side == 0) && k < 20) begin
      bus_in = 8'($urandom); tick(); k++;
    end
    check_val("t5_reach_rx", k < 20, 1'b1);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_val("t5_rxv", rx_valid, 1'b0);
    check_val("t5_rxd", rx_data, 8'h00);
    tx_req = 1'b1; rx_req = 1'b1;
    tick(); tick(); tick();
    #1;
    check_val("t5_tie_tx", tx_ack, 1'b1);
    tx_req = 1'b0; rx_req = 1'b0; tick(); tick(); tick();

    // transmit request withdrawn during turnaround: zero-byte grant
    ena = 1'b0; tick(); ena = 1'b1;
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_val("t6_oe", bus_oe, 8'hFF);
    check_val("t6_busy", busy, 1'b0);

    // random traffic, then heavy traffic that reaches the burst cap
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ena = ($urandom_range(0, 39) != 0);
      tx_req = ($urandom_range(0, 9) < 7);
      rx_req = ($urandom_range(0, 9) < 6);
      tx_last = ($urandom_range(0, 4) == 0);
      tx_data = 8'($urandom); bus_in = 8'($urandom);
      tick();
    end
    rst_n = 1'b1; ena = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tx_req = ($urandom_range(0, 19) != 0);
      rx_req = ($urandom_range(0, 19) != 0);
      tx_last = ($urandom_range(0, 19) == 0);
      tx_data = 8'($urandom); bus_in = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
